dlx_issue_stage: RTL

- Single-issue decode/operand-fetch/writeback sequencer placed directly upstream of the DLX ALU.
- Accepts one 32-bit DLX ALU-class instruction over a valid/ready handshake and reads the 32x32 register file.
- Drives the ALU opcode, operands and execute strobe, then writes the registered ALU result back to rd.
- Latches the ALU carry and zero flags into a status register.

---
 rtl/dlx_issue_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dlx_issue_stage.sv
// DLX issue stage: decodes one ALU-class instruction, reads the register file,
// strobes the downstream registered ALU and writes its result back to rd.
module dlx_issue_stage #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              alu_ex,
    output logic [3:0]        alu_i,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_carry,
    input  logic              alu_z,
    output logic              done,
    output logic              illegal,
    output logic              flag_c,
    output logic              flag_z,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    localparam logic [5:0] OP_LHI = 6'h0F;

    state_t            r_state;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [3:0]        r_alu_i;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_ex;
    logic              r_done;
    logic              r_illegal;
    logic              r_flag_c;
    logic              r_flag_z;

    logic [5:0]        w_opcode;
    logic [5:0]        w_func;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    logic              w_rtype;
    logic              w_legal;
    logic              w_sext;
    logic [3:0]        w_alu_i;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    assign w_opcode = r_instr[31:26];
    assign w_rs1    = r_instr[25:21];
    assign w_rs2    = r_instr[20:16];
    assign w_func   = r_instr[5:0];
    assign w_rtype  = (w_opcode == 6'h00);
    assign w_rd     = w_rtype ? r_instr[15:11] : r_instr[20:16];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_legal = 1'b1;
        w_sext  = 1'b0;
        w_alu_i = 4'd0;
        if (w_rtype) begin
            case (w_func)
                6'h20:   w_alu_i = 4'd1;
                6'h22:   w_alu_i = 4'd2;
                6'h24:   w_alu_i = 4'd3;
                6'h25:   w_alu_i = 4'd4;
                6'h26:   w_alu_i = 4'd5;
                6'h04:   w_alu_i = 4'd6;
                6'h06:   w_alu_i = 4'd7;
                6'h07:   w_alu_i = 4'd14;
                6'h28:   w_alu_i = 4'd10;
                6'h29:   w_alu_i = 4'd13;
                6'h2A:   w_alu_i = 4'd12;
                6'h2C:   w_alu_i = 4'd11;
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (w_opcode)
                6'h08:   begin w_alu_i = 4'd1;  w_sext = 1'b1; end
                6'h0A:   begin w_alu_i = 4'd2;  w_sext = 1'b1; end
                6'h0C:   w_alu_i = 4'd3;
                6'h0D:   w_alu_i = 4'd4;
                6'h0E:   w_alu_i = 4'd5;
                OP_LHI:  w_alu_i = 4'd0;
                6'h14:   w_alu_i = 4'd6;
                6'h16:   w_alu_i = 4'd7;
                6'h17:   w_alu_i = 4'd14;
                6'h18:   begin w_alu_i = 4'd10; w_sext = 1'b1; end
                6'h19:   begin w_alu_i = 4'd13; w_sext = 1'b1; end
                6'h1A:   begin w_alu_i = 4'd12; w_sext = 1'b1; end
                6'h1C:   begin w_alu_i = 4'd11; w_sext = 1'b1; end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_imm_ext = w_sext ? {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]}
                              : {{(DATA_W-16){1'b0}}, r_instr[15:0]};
    // LHI ignores rs1 so the ALU's <<16 sees a clean zero operand.
    assign w_op1     = (w_opcode == OP_LHI) ? '0 : r_regs[w_rs1];
    assign w_op2     = w_rtype ? r_regs[w_rs2] : w_imm_ext;

    // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_alu_i   <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_ex      <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            // NOTE: the register file is small and must read back zero after reset, so it lives in flops.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_ex      <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_alu_i <= w_alu_i;
                        r_op1   <= w_op1;
                        r_op2   <= w_op2;
                        r_ex    <= 1'b1;
                        r_state <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_rd != 5'd0) r_regs[w_rd] <= alu_res;
                    r_flag_c <= alu_carry;
                    r_flag_z <= alu_z;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign alu_ex      = r_ex;
    assign alu_i       = r_alu_i;
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

endmodule
